// File: rtl/qam_rx_pkg.sv
// Shared defaults and types for the QAM receive decimation path.
package qam_rx_pkg;

  localparam int unsigned DEF_DATA_W     = 4;
  localparam int unsigned DEF_OSR        = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] i;
    logic [DEF_DATA_W-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/qam_sym_fifo.sv
// Synchronous symbol FIFO with a register-array head and wrap-around occupancy counters.
module qam_sym_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic             do_pop;
  logic             do_push;

  // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
  always_comb begin
    level   = wr_cnt - rd_cnt;
    full    = (level == FULL_LVL);
    empty   = (level == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_cnt[AW-1:0]] <= wdata;
        wr_cnt              <= wr_cnt + ONE;
      end
      if (do_pop) begin
        rd_cnt <= rd_cnt + ONE;
      end
    end
  end

  assign rdata = mem[rd_cnt[AW-1:0]];

endmodule

// File: rtl/qam_rx_downsampler.sv
// Oversampled I/Q input pipeline, phase-selectable decimator and buffered symbol output.
module qam_rx_downsampler
  import qam_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned OSR        = DEF_OSR,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_i,
  input  logic [DATA_W-1:0]             in_q,
  input  logic                          phase_load,
  input  logic [$clog2(OSR)-1:0]        phase_sel,
  input  logic                          clr_ovf,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic [DATA_W-1:0]             sym_i,
  output logic [DATA_W-1:0]             sym_q,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned PW   = $clog2(OSR);
  localparam logic [PW-1:0] LAST = PW'(OSR - 1);
  localparam logic [PW-1:0] STEP = PW'(1);

  logic              s1_valid;
  logic              s2_valid;
  logic [DATA_W-1:0] s1_i;
  logic [DATA_W-1:0] s1_q;
  logic [DATA_W-1:0] s2_i;
  logic [DATA_W-1:0] s2_q;
  state_t            state;
  logic [PW-1:0]     cnt;
  logic [PW-1:0]     phase_reg;
  logic              sel_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*DATA_W-1:0] head;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_i     <= '0;
      s1_q     <= '0;
      s2_i     <= '0;
      s2_q     <= '0;
    end else begin
      s1_valid <= in_valid && !phase_load;
      s2_valid <= s1_valid && !phase_load;
      s1_i     <= in_i;
      s1_q     <= in_q;
      s2_i     <= s1_i;
      s2_q     <= s1_q;
    end
  end

  // IDLE keeps cnt at 0, so the first post-flush sample is compared as count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      phase_reg <= '0;
    end else if (phase_load) begin
      state     <= IDLE;
      cnt       <= '0;
      phase_reg <= (phase_sel > LAST) ? LAST : phase_sel;
    end else if (s2_valid) begin
      case (state)
        IDLE: begin
          state <= RUN;
          cnt   <= STEP;
        end
        RUN: begin
          cnt <= (cnt == LAST) ? '0 : cnt + STEP;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The sample sitting in stage2 on a reload edge is in flight and is discarded.
  assign sel_push = s2_valid && !phase_load && (cnt == phase_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (sel_push && fifo_full && !sym_ready) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  qam_sym_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sel_push),
    .pop   (sym_ready),
    .wdata ({s2_i, s2_q}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign sym_valid = !fifo_empty;
  assign sym_i     = head[2*DATA_W-1:DATA_W];
  assign sym_q     = head[DATA_W-1:0];

endmodule
